descriptor_packetizer: RTL and testbench
========================================

Name: descriptor_packetizer

Overview:
- Downstream consumer of the descriptor ROM: services a GET_DESCRIPTOR request by walking ROM addresses and splitting the descriptor into endpoint-0 DATA packets of at most 8 bytes.
- Streams the packet bytes to the USB transmit serializer over a valid/ready byte handshake.
- Handles DATA0/DATA1 toggling, retransmission on a missing ACK, and the terminating zero-length packet (ZLP).
- Sits between the control-request decoder and the bit serializer / CRC block.

Parameters:
- MAX_PKT, 8: endpoint-0 max packet size in bytes.
- DEV_BASE, 1: ROM address of the first device-descriptor byte.
- DEV_LEN, 18: device descriptor length in bytes.
- CFG_BASE, 19: ROM address of the first configuration-descriptor byte.
- CFG_LEN, 32: total configuration length in bytes (wTotalLength).

Ports:
- useClk  in  1  single clock for the whole block.
- rstN  in  1  asynchronous, active-low reset.
- reqValid  in  1  one-cycle request strobe; sampled only in IDLE.
- reqType  in  2  1 = device descriptor, 2 = configuration descriptor; all other values are unsupported.
- reqLength  in  16  wLength from the SETUP packet.
- abort  in  1  new SETUP received or bus reset; cancels the transfer.
- reqReady  out  1  high only in IDLE.
- romCheckData  out  1  ROM read enable.
- romAddr  out  6  ROM address.
- romData  in  8  ROM output; valid 1 cycle after romCheckData is high.
- pktStart  out  1  1-cycle pulse at the start of each packet (including retries and ZLP); dataPid is valid with it.
- dataPid  out  4  4'b1011 = DATA1, 4'b0011 = DATA0.
- txValid  out  1  txData is valid.
- txData  out  8  packet byte.
- txLast  out  1  marks the final byte of a packet.
- txReady  in  1  serializer accepts the byte when txValid && txReady.
- pktEnd  out  1  1-cycle pulse after the last byte of a packet is accepted (also issued for a ZLP).
- hostAck  in  1  host ACKed the current packet.
- hostRetry  in  1  timeout or corrupt handshake; the current packet must be resent.
- stall  out  1  1-cycle pulse: request is unsupported.
- done  out  1  1-cycle pulse: the transfer is complete.

Behaviour:
- Reset: all outputs are 0 except reqReady = 1 and dataPid = 4'b1011; state = IDLE.
- IDLE, on reqValid:
  - Unsupported reqType: pulse stall, stay in IDLE.
  - Otherwise latch base and descLen.
  - xferLen = min(reqLength, descLen), compared in 16 bits.
  - needZlp = (xferLen < reqLength) && (xferLen % MAX_PKT == 0).
  - Set pid = DATA1 and go to PKT_START.
- PKT_START:
  - pktBase = current pointer; pulse pktStart; zero the byte counter.
  - Bytes in this packet: pktLen = min(MAX_PKT, xferLen - sent).
  - If pktLen = 0 (ZLP, or reqLength = 0), pulse pktEnd next cycle and go to WAIT_HS; a ZLP issues no txValid.
  - Otherwise go to FETCH.
- FETCH: drive romCheckData = 1 and romAddr = base + sent + byteCnt (6-bit, no wrap by construction); go to WAIT.
- WAIT: capture romData into the output register; go to SEND.
- SEND:
  - Assert txValid with the captured byte; txLast = (byteCnt == pktLen - 1).
  - txData, txValid and txLast stay stable until txReady.
  - On acceptance: if txLast, pulse pktEnd and go to WAIT_HS; otherwise byteCnt++ and go to FETCH.
  - Gap between an accepted byte and the next txValid is exactly 2 cycles.
- WAIT_HS:
  - hostAck: sent += pktLen and toggle pid.
    - If sent == xferLen and no ZLP is pending, pulse done and go to IDLE.
    - Otherwise go to PKT_START (the ZLP is issued after the last full packet).
  - hostRetry: pointer returns to pktBase, pid unchanged, go to PKT_START.
  - hostAck and hostRetry in the same cycle: hostRetry wins.
- abort:
  - Takes effect in any state on the next clock edge: state = IDLE, txValid = 0, no done or pktEnd pulse, pid = DATA1.
  - abort wins over every other simultaneous input.
- hostAck or hostRetry outside WAIT_HS is ignored.

Test Plan:
- Device request, reqLength = 64 -> packets of 8, 8, 2 bytes; ROM addrs 1..18; PIDs DATA1, DATA0, DATA1; 18 is not a multiple of 8, so no ZLP; done after the 3rd ACK.
- Config request, reqLength = 255 -> 4 × 8 bytes from addrs 19..50, then a ZLP with pid DATA1 (the 5th packet), then done.
- Device request, reqLength = 8 -> one 8-byte packet (0x12, 0x01, 0x10, 0x01, 0x00, 0x00, 0x00, 0x08); xferLen = reqLength, so no ZLP; done.
- hostRetry after packet 2 of the device request -> packet 2 is resent with identical bytes (addr 9..16) and pid DATA0; txReady held low for 5 cycles in SEND -> txData stays stable throughout.
- reqType = 3 -> single stall pulse, no romCheckData, reqReady stays high; reqLength = 0 with a device request -> a single ZLP with DATA1, then done.
- abort asserted mid-SEND of packet 1, and separately rstN pulsed low mid-FETCH -> txValid is 0 by the next edge (immediately for rstN), state is IDLE, no done pulse.

Source files
------------

// File: rtl/descriptor_packetizer.sv
// Endpoint-0 descriptor packetizer: walks the descriptor ROM for a GET_DESCRIPTOR
// request and streams DATA0/DATA1 packets (with retry and ZLP) to the serializer.
module descriptor_packetizer #(
   parameter int MAX_PKT  = 8,
   parameter int DEV_BASE = 1,
   parameter int DEV_LEN  = 18,
   parameter int CFG_BASE = 19,
   parameter int CFG_LEN  = 32
) (
   input  logic        useClk,
   input  logic        rstN,
   input  logic        reqValid,
   input  logic [1:0]  reqType,
   input  logic [15:0] reqLength,
   input  logic        abort,
   output logic        reqReady,
   output logic        romCheckData,
   output logic [5:0]  romAddr,
   input  logic [7:0]  romData,
   output logic        pktStart,
   output logic [3:0]  dataPid,
   output logic        txValid,
   output logic [7:0]  txData,
   output logic        txLast,
   input  logic        txReady,
   output logic        pktEnd,
   input  logic        hostAck,
   input  logic        hostRetry,
   output logic        stall,
   output logic        done
);

   localparam int CW = $clog2(MAX_PKT + 1);
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_DATA0 = 4'b0011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PKT_START,
      S_FETCH,
      S_WAIT,
      S_SEND,
      S_WAIT_HS
   } state_t;

   state_t          state_q, state_d;
   logic [5:0]      base_q, base_d;
   logic [15:0]     xfer_len_q, xfer_len_d;
   logic [15:0]     sent_q, sent_d;
   logic            zlp_q, zlp_d;
   logic [3:0]      pid_q, pid_d;
   logic [CW-1:0]   pkt_len_q, pkt_len_d;
   logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [7:0]      data_q, data_d;
   logic            pkt_end_q, pkt_end_d;
   logic            stall_q, stall_d;
   logic            done_q, done_d;

   logic            supported_c;
   logic [5:0]      sel_base_c;
   logic [15:0]     sel_len_c;
   logic [15:0]     xfer_len_c;
   logic            need_zlp_c;
   logic [15:0]     remaining_c;
   logic [CW-1:0]   pkt_len_c;
   logic [15:0]     sent_plus_c;
   logic            last_byte_c;
   logic            zlp_left_c;

   // Request decode: descriptor selection and transfer sizing
   always_comb begin
      supported_c = (reqType == 2'd1) || (reqType == 2'd2);
      sel_base_c  = (reqType == 2'd2) ? 6'(CFG_BASE) : 6'(DEV_BASE);
      sel_len_c   = (reqType == 2'd2) ? 16'(CFG_LEN) : 16'(DEV_LEN);
      xfer_len_c  = (reqLength < sel_len_c) ? reqLength : sel_len_c;
      need_zlp_c  = (xfer_len_c < reqLength) &&
                    ((xfer_len_c % 16'(MAX_PKT)) == 16'd0);
   end

   always_comb begin
      remaining_c = xfer_len_q - sent_q;
      pkt_len_c   = (remaining_c >= 16'(MAX_PKT)) ? CW'(MAX_PKT) : remaining_c[CW-1:0];
      sent_plus_c = sent_q + 16'(pkt_len_q);
      last_byte_c = (byte_cnt_q == (pkt_len_q - CW'(1)));
      // A ZLP is still owed only while the packet being acked carried data
      zlp_left_c  = zlp_q && (pkt_len_q != '0);
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      xfer_len_d = xfer_len_q;
      sent_d     = sent_q;
      zlp_d      = zlp_q;
      pid_d      = pid_q;
      pkt_len_d  = pkt_len_q;
      byte_cnt_d = byte_cnt_q;
      data_d     = data_q;
      pkt_end_d  = 1'b0;
      stall_d    = 1'b0;
      done_d     = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
         pid_d   = PID_DATA1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (reqValid) begin
                  if (!supported_c) begin
                     stall_d = 1'b1;
                  end else begin
                     base_d     = sel_base_c;
                     xfer_len_d = xfer_len_c;
                     zlp_d      = need_zlp_c;
                     sent_d     = 16'd0;
                     pid_d      = PID_DATA1;
                     state_d    = S_PKT_START;
                  end
               end
            end
            S_PKT_START: begin
               pkt_len_d  = pkt_len_c;
               byte_cnt_d = '0;
               if (pkt_len_c == '0) begin
                  pkt_end_d = 1'b1;
                  state_d   = S_WAIT_HS;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_FETCH: begin
               state_d = S_WAIT;
            end
            S_WAIT: begin
               data_d  = romData;
               state_d = S_SEND;
            end
            S_SEND: begin
               if (txReady) begin
                  if (last_byte_c) begin
                     pkt_end_d = 1'b1;
                     state_d   = S_WAIT_HS;
                  end else begin
                     byte_cnt_d = byte_cnt_q + CW'(1);
                     state_d    = S_FETCH;
                  end
               end
            end
            S_WAIT_HS: begin
               // Retry leaves sent untouched, so the packet restarts at its base
               if (hostRetry) begin
                  state_d = S_PKT_START;
               end else if (hostAck) begin
                  sent_d = sent_plus_c;
                  pid_d  = (pid_q == PID_DATA1) ? PID_DATA0 : PID_DATA1;
                  zlp_d  = zlp_left_c;
                  if ((sent_plus_c == xfer_len_q) && !zlp_left_c) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_PKT_START;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge useClk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         xfer_len_q <= '0;
         sent_q     <= '0;
         zlp_q      <= 1'b0;
         pid_q      <= PID_DATA1;
         pkt_len_q  <= '0;
         byte_cnt_q <= '0;
         data_q     <= '0;
         pkt_end_q  <= 1'b0;
         stall_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         xfer_len_q <= xfer_len_d;
         sent_q     <= sent_d;
         zlp_q      <= zlp_d;
         pid_q      <= pid_d;
         pkt_len_q  <= pkt_len_d;
         byte_cnt_q <= byte_cnt_d;
         data_q     <= data_d;
         pkt_end_q  <= pkt_end_d;
         stall_q    <= stall_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      reqReady     = (state_q == S_IDLE);
      romCheckData = (state_q == S_FETCH);
      romAddr      = base_q + sent_q[5:0] + 6'(byte_cnt_q);
      pktStart     = (state_q == S_PKT_START);
      dataPid      = pid_q;
      txValid      = (state_q == S_SEND);
      txData       = data_q;
      txLast       = (state_q == S_SEND) && last_byte_c;
      pktEnd       = pkt_end_q;
      stall        = stall_q;
      done         = done_q;
   end

endmodule

// File: tb/tb_descriptor_packetizer.sv
// Scoreboard bench for descriptor_packetizer: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_descriptor_packetizer;

   logic        useClk = 1'b0;
   logic        rstN;
   logic        reqValid = 1'b0;
   logic [1:0]  reqType = 2'd0;
   logic [15:0] reqLength = 16'd0;
   logic        abort = 1'b0;
   logic        reqReady;
   logic        romCheckData;
   logic [5:0]  romAddr;
   logic [7:0]  romData = 8'd0;
   logic        pktStart;
   logic [3:0]  dataPid;
   logic        txValid;
   logic [7:0]  txData;
   logic        txLast;
   logic        txReady = 1'b1;
   logic        pktEnd;
   logic        hostAck = 1'b0;
   logic        hostRetry = 1'b0;
   logic        stall;
   logic        done;

   always #5 useClk = ~useClk;

   descriptor_packetizer dut (
      .useClk(useClk), .rstN(rstN), .reqValid(reqValid), .reqType(reqType),
      .reqLength(reqLength), .abort(abort), .reqReady(reqReady),
      .romCheckData(romCheckData), .romAddr(romAddr), .romData(romData),
      .pktStart(pktStart), .dataPid(dataPid), .txValid(txValid), .txData(txData),
      .txLast(txLast), .txReady(txReady), .pktEnd(pktEnd), .hostAck(hostAck),
      .hostRetry(hostRetry), .stall(stall), .done(done)
   );

   localparam int K_START = 0, K_ADDR = 1, K_BYTE = 2, K_END = 3, K_DONE = 4, K_STALL = 5;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   ev_t        exp_q[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] rom [0:63];

   always @(posedge useClk) if (romCheckData) romData <= rom[romAddr];

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic take(input int kind, input int val, input string name);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: unexpected output 0x%0h with nothing expected", name, val);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_kind"}, kind, e.kind);
         if (kind == e.kind) chk(name, val, e.val);
      end
   endtask

   logic       hold_v = 1'b0;
   logic [7:0] hold_data = 8'd0;

   always @(negedge useClk) begin
      if (pktStart)          take(K_START, int'(dataPid), "pid");
      if (romCheckData)      take(K_ADDR, int'(romAddr), "rom_addr");
      if (txValid && hold_v) chk("tx_stable", int'(txData), int'(hold_data));
      if (txValid && txReady) take(K_BYTE, int'({txLast, txData}), "tx_byte");
      if (pktEnd)            take(K_END, 0, "pkt_end");
      if (done)              take(K_DONE, 0, "done");
      if (stall)             take(K_STALL, 0, "stall");
      hold_v    <= txValid && !txReady;
      hold_data <= txData;
   end

   task automatic tick();
      @(posedge useClk);
      #1;
   endtask

   task automatic push(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic push_pkt(input logic [3:0] pid, input int a0, input int n);
      push(K_START, int'(pid));
      for (int i = 0; i < n; i++) begin
         push(K_ADDR, a0 + i);
         push(K_BYTE, ((i == n - 1) ? 256 : 0) + int'(rom[a0 + i]));
      end
      push(K_END, 0);
   endtask

   task automatic wait_pkt_end(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge useClk);
         if (pktEnd) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s: timed out waiting for pkt_end", name);
      end
   endtask

   task automatic handshake(input bit retry);
      tick();
      if (retry) hostRetry = 1'b1;
      else       hostAck   = 1'b1;
      tick();
      hostAck   = 1'b0;
      hostRetry = 1'b0;
   endtask

   task automatic request(input logic [1:0] typ, input logic [15:0] len);
      reqValid  = 1'b1;
      reqType   = typ;
      reqLength = len;
      tick();
      reqValid = 1'b0;
   endtask

   // Builds the expected packet sequence for a request, then drives the handshakes
   task automatic run_xfer(input logic [1:0] typ, input int len, input int retry_pkt,
                           input int slow_pkt);
      int base, dlen, xl, sent, n, k, cnt;
      bit pending;
      logic [3:0] pid;
      base    = (typ == 2'd1) ? 1 : 19;
      dlen    = (typ == 2'd1) ? 18 : 32;
      xl      = (len < dlen) ? len : dlen;
      pending = (xl < len) && (xl % 8 == 0);
      sent    = 0;
      pid     = 4'b1011;
      k       = 0;
      do begin
         n = (xl - sent > 8) ? 8 : xl - sent;
         push_pkt(pid, base + sent, n);
         if (k == retry_pkt) push_pkt(pid, base + sent, n);
         if (n == 0) pending = 1'b0;
         sent += n;
         pid = (pid == 4'b1011) ? 4'b0011 : 4'b1011;
         k++;
      end while (sent < xl || pending);
      push(K_DONE, 0);

      request(typ, 16'(len));
      for (int p = 0; p < k; p++) begin
         if (p == slow_pkt) begin
            txReady = 1'b0;
            cnt = 0;
            for (int i = 0; i < 200 && cnt < 5; i++) begin
               @(negedge useClk);
               if (txValid) cnt++;
            end
            tick();
            txReady = 1'b1;
         end
         wait_pkt_end("xfer_pkt_end");
         if (p == retry_pkt) begin
            handshake(1'b1);
            wait_pkt_end("retry_pkt_end");
         end
         handshake(1'b0);
      end
      repeat (3) tick();
      chk("xfer_queue_drained", exp_q.size(), 0);
      $display("transfer type=%0d len=%0d packets=%0d total=%0d bad=%0d", typ, len, k, total, bad);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] dev8 [8];
      bit seen;
      dev8 = '{8'h12, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08};
      for (int i = 0; i < 64; i++) rom[i] = 8'(i * 13 + 5);
      for (int i = 0; i < 8; i++) rom[i + 1] = dev8[i];

      rstN = 1'b0;
      repeat (3) @(posedge useClk);
      #1;
      chk("rst_reqReady", int'(reqReady), 1);
      chk("rst_dataPid", int'(dataPid), 'hB);
      chk("rst_txValid", int'(txValid), 0);
      chk("rst_romCheckData", int'(romCheckData), 0);
      chk("rst_pktStart", int'(pktStart), 0);
      chk("rst_pktEnd", int'(pktEnd), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_stall", int'(stall), 0);
      chk("rst_txData", int'(txData), 0);
      rstN = 1'b1;
      tick();

      run_xfer(2'd1, 64, -1, -1);
      run_xfer(2'd2, 255, -1, -1);
      run_xfer(2'd1, 8, -1, -1);
      run_xfer(2'd1, 64, 1, 1);

      // Unsupported request type
      push(K_STALL, 0);
      request(2'd3, 16'd64);
      repeat (3) begin
         @(negedge useClk);
         chk("stall_reqReady", int'(reqReady), 1);
      end
      tick();
      chk("stall_queue_drained", exp_q.size(), 0);
      $display("stall request total=%0d bad=%0d", total, bad);

      run_xfer(2'd1, 0, -1, -1);

      // Abort while the first byte is waiting on txReady
      push(K_START, 'hB);
      push(K_ADDR, 1);
      txReady = 1'b0;
      request(2'd1, 16'd64);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge useClk);
         if (txValid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("abort_reached_send", int'(seen), 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_txValid", int'(txValid), 0);
      chk("abort_reqReady", int'(reqReady), 1);
      chk("abort_dataPid", int'(dataPid), 'hB);
      repeat (10) tick();
      txReady = 1'b1;
      chk("abort_queue_drained", exp_q.size(), 0);
      $display("abort in send total=%0d bad=%0d", total, bad);

      // Reset pulse while fetching
      push(K_START, 'hB);
      push(K_ADDR, 1);
      request(2'd1, 16'd64);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge useClk);
         if (romCheckData) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rstn_reached_fetch", int'(seen), 1);
      #1 rstN = 1'b0;
      #1;
      chk("rstn_txValid", int'(txValid), 0);
      chk("rstn_romCheckData", int'(romCheckData), 0);
      chk("rstn_reqReady", int'(reqReady), 1);
      tick();
      tick();
      rstN = 1'b1;
      repeat (5) tick();
      chk("rstn_queue_drained", exp_q.size(), 0);
      $display("reset in fetch total=%0d bad=%0d", total, bad);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
